// File: rtl/disp7seg_pkg.sv
// Shared constants for the 4-digit seven-segment display controller.
package disp7seg_pkg;

    typedef enum logic [1:0] {
        ADDR_DIG10 = 2'd0,
        ADDR_DIG32 = 2'd1,
        ADDR_MASK  = 2'd2,
        ADDR_CTRL  = 2'd3
    } reg_addr_e;

    localparam logic [7:0] CTRL_RESET = 8'h01;
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [3:0] AN_OFF     = 4'b1111;

endpackage

// File: rtl/disp7seg_ctrl_if.sv
// CPU I/O port bus between the processor core and the display controller.
interface disp7seg_ctrl_if;

    logic       io_we;
    logic [1:0] io_addr;
    logic [7:0] io_din;
    logic [7:0] io_dout;

    modport master (output io_we, io_addr, io_din, input io_dout);
    modport slave  (input io_we, io_addr, io_din, output io_dout);

endinterface

// File: rtl/disp7seg_ctrl_hex_to_7seg.sv
// Combinational hex digit to active-low segment decoder, bit order {g,f,e,d,c,b,a}.
module hex_to_7seg (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        unique case (hex)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/disp7seg_ctrl.sv
// Memory-mapped 4-digit multiplexed seven-segment display controller.
// Optional digit blinking is compiled in with DISP7SEG_BLINK_EN.
module disp7seg_ctrl
    import disp7seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 12500,
    parameter int unsigned BLINK_FRAMES = 256
) (
    input  logic             clk,
    input  logic             reset,
    disp7seg_ctrl_if.slave   io,
    output logic [3:0]       an_out,
    output logic [6:0]       seg_out,
    output logic             dp_out
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

    if (REFRESH_DIV < 2 || BLINK_FRAMES < 1) begin : g_param_check
        $error("disp7seg_ctrl: REFRESH_DIV must be >= 2 and BLINK_FRAMES >= 1");
    end

    logic [7:0]       dig10;
    logic [7:0]       dig32;
    logic [7:0]       mask_r;
    logic             ctrl_en;
    logic [3:0]       blink_mask;
    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       idx;
    logic             scan_term;
    logic [7:0]       rd_data;
    logic [3:0]       cur_digit;
    logic [6:0]       cur_seg;
    logic [3:0]       eff_blank;

    assign scan_term = (scan_cnt == CNT_W'(REFRESH_DIV - 1));

`ifdef DISP7SEG_BLINK_EN
    localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FRM_W-1:0] frame_cnt;
    logic             blink_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_mask  <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (io.io_we && reg_addr_e'(io.io_addr) == ADDR_CTRL)
                blink_mask <= io.io_din[7:4];
            // A frame ends when the last digit's slot expires.
            if (scan_term && idx == 2'd3) begin
                if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    assign eff_blank = mask_r[7:4] | (blink_phase ? blink_mask : 4'b0000);
`else
    assign blink_mask = '0;
    assign eff_blank  = mask_r[7:4];
`endif

    always_comb begin
        rd_data = '0;
        unique case (reg_addr_e'(io.io_addr))
            ADDR_DIG10: rd_data = dig10;
            ADDR_DIG32: rd_data = dig32;
            ADDR_MASK:  rd_data = mask_r;
            ADDR_CTRL:  rd_data = {blink_mask, 3'b000, ctrl_en};
        endcase
    end

    always_comb begin
        cur_digit = '0;
        unique case (idx)
            2'd0: cur_digit = dig10[3:0];
            2'd1: cur_digit = dig10[7:4];
            2'd2: cur_digit = dig32[3:0];
            2'd3: cur_digit = dig32[7:4];
        endcase
    end

    hex_to_7seg u_hex (
        .hex (cur_digit),
        .seg (cur_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            dig10      <= '0;
            dig32      <= '0;
            mask_r     <= '0;
            ctrl_en    <= CTRL_RESET[0];
            io.io_dout <= '0;
            scan_cnt   <= '0;
            idx        <= '0;
            an_out     <= AN_OFF;
            seg_out    <= SEG_BLANK;
            dp_out     <= 1'b1;
        end else begin
            if (io.io_we) begin
                unique case (reg_addr_e'(io.io_addr))
                    ADDR_DIG10: dig10   <= io.io_din;
                    ADDR_DIG32: dig32   <= io.io_din;
                    ADDR_MASK:  mask_r  <= io.io_din;
                    ADDR_CTRL:  ctrl_en <= io.io_din[0];
                endcase
            end

            io.io_dout <= rd_data;

            if (scan_term) begin
                scan_cnt <= '0;
                idx      <= idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end

            if (ctrl_en && !eff_blank[idx]) begin
                an_out  <= ~(4'b0001 << idx);
                seg_out <= cur_seg;
                dp_out  <= ~mask_r[idx];
            end else begin
                an_out  <= AN_OFF;
                seg_out <= SEG_BLANK;
                dp_out  <= 1'b1;
            end
        end
    end

endmodule
